fifo_rd_drain: RTL

- Read-side controller for the team's synchronous FIFO (WIDTH 8, DEPTH 16).
- Watches empty_i and issues rd_en_o pops, absorbing the FIFO's one-cycle registered read latency.
- Buffers returned words in a 3-entry skid buffer and presents them on a valid/ready stream to the downstream consumer.
- Counts delivered words and latches FIFO read errors.

---
 rtl/fifo_rd_drain.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller for the synchronous FIFO.
// It issues credit-limited pops and absorbs the one-cycle read latency in a 3-entry skid buffer.
module fifo_rd_drain #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 empty_i,
    output logic                 rd_en_o,
    input  logic [WIDTH-1:0]     rdata_i,
    input  logic                 rd_error_i,
    output logic                 m_valid_o,
    output logic [WIDTH-1:0]     m_data_o,
    input  logic                 m_ready_i,
    output logic [CNT_WIDTH-1:0] rd_count_o,
    output logic                 err_o,
    output logic                 idle_o
);

    localparam int unsigned Entries = 3;

    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q;
    logic [1:0]           head_q, head_d;
    logic [1:0]           tail_q, tail_d;
    logic [WIDTH-1:0]     buf_q [Entries];
    logic [WIDTH-1:0]     last_q, last_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 err_q;
    logic [2:0]           credit_used;
    logic                 xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Slots already spoken for: buffered words plus the word returning next cycle.
    assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q};

    always_comb begin
        rd_en_o    = ~rst_i & en_i & ~empty_i & (credit_used < 3'd3);
        m_valid_o  = (occ_q != 2'd0);
        xfer       = m_valid_o & m_ready_i;
        // With the buffer empty, keep showing the most recently delivered word.
        m_data_o   = m_valid_o ? buf_q[head_q] : last_q;
        idle_o     = (occ_q == 2'd0) & ~inflight_q;
        rd_count_o = count_q;
        err_o      = err_q;
    end

    always_comb begin
        occ_d   = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
        head_d  = head_q;
        tail_d  = tail_q;
        last_d  = last_q;
        count_d = count_q;
        if (xfer) begin
            head_d  = ptr_inc(head_q);
            last_d  = buf_q[head_q];
            count_d = count_q + CNT_WIDTH'(1);
        end
        if (inflight_q) begin
            tail_d = ptr_inc(tail_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            last_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < Entries; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= rd_en_o;
            head_q     <= head_d;
            tail_q     <= tail_d;
            last_q     <= last_d;
            count_q    <= count_d;
            err_q      <= err_q | rd_error_i;
            if (inflight_q) begin
                buf_q[tail_q] <= rdata_i;
            end
        end
    end

endmodule
